// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR filter and its output requantisation stage.
package fir_pkg;

    localparam int FIR_IN_W      = 40;
    localparam int FIR_OUT_W     = 16;
    localparam int FIR_COEF_FRAC = 15;

    typedef logic signed [FIR_IN_W-1:0]  fir_acc_t;
    typedef logic signed [FIR_OUT_W-1:0] fir_sample_t;

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted only alongside a pop.
module fir_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    // Storage is cleared on reset so the output reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_requant_decim.sv
// Round, saturate and decimate the FIR accumulator into a buffered 16-bit sample stream.
// Optional saturation counter enabled by defining FIR_REQUANT_STATS_EN.
module fir_requant_decim
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = FIR_COEF_FRAC,
    parameter int DECIM = 1,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  in_sample,
    input  logic                    in_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_flag,
    output logic                    ovf_flag,
    input  logic                    clr_flags,
    output logic [15:0]             sat_count
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [IN_W:0] RND    = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] SAT_LO = ~SAT_HI;

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] in_ext;
    logic signed [IN_W:0] rnd_sum;
    logic signed [IN_W:0] r_data;
    logic                 r_valid;
    logic [PH_W-1:0]      ph;
    logic [OUT_W-1:0]     s_data;
    logic                 s_valid;
    logic                 s_sat;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 sat_evt;
    logic                 ovf_evt;
    logic [OUT_W-1:0]     fifo_dout;

    // One guard bit keeps the rounding add from wrapping at the top of the range.
    assign in_ext  = {in_sample[IN_W-1], in_sample};
    assign rnd_sum = in_ext + RND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_data  <= rnd_sum >>> SHIFT;
            r_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph      <= '0;
            s_data  <= '0;
            s_valid <= 1'b0;
            s_sat   <= 1'b0;
        end else begin
            s_valid <= r_valid && (ph == '0);
            if (r_data > SAT_HI) begin
                s_data <= OUT_MAX;
                s_sat  <= 1'b1;
            end else if (r_data < SAT_LO) begin
                s_data <= OUT_MIN;
                s_sat  <= 1'b1;
            end else begin
                s_data <= r_data[OUT_W-1:0];
                s_sat  <= 1'b0;
            end
            if (r_valid) begin
                ph <= (ph == PH_W'(DECIM - 1)) ? '0 : ph + 1'b1;
            end
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout;
    assign pop       = out_valid && out_ready;
    assign sat_evt   = s_valid && s_sat;
    assign ovf_evt   = s_valid && fifo_full && !pop;

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .pop   (pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A set event in the same cycle as clr_flags leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (sat_evt) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end
            if (ovf_evt) begin
                ovf_flag <= 1'b1;
            end else if (clr_flags) begin
                ovf_flag <= 1'b0;
            end
        end
    end

`ifdef FIR_REQUANT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_evt) begin
            if (sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 1'b1;
            end
        end else if (clr_flags) begin
            sat_count <= '0;
        end
    end
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_requant_decim.sv
// Bench for fir_requant_decim: vector table, hand sequences and random stimulus against a queue model.
module tb_fir_requant_decim;

    localparam int DEPTH = 4;
    localparam int SHIFT = 15;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [39:0] in_a = '0, in_b = '0;
    logic               iva = 1'b0, ivb = 1'b0, ra = 1'b0, rb = 1'b1, clr = 1'b0;
    logic signed [15:0] od_a, od_b;
    logic               ova, ovb, sfa, sfb, ofa, ofb;
    logic [15:0]        sca, scb;

    always #5 clk = ~clk;

    fir_requant_decim #(.SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_sample(in_a), .in_valid(iva),
        .out_data(od_a), .out_valid(ova), .out_ready(ra),
        .sat_flag(sfa), .ovf_flag(ofa), .clr_flags(clr), .sat_count(sca));

    fir_requant_decim #(.SHIFT(SHIFT), .DECIM(3), .DEPTH(DEPTH)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_sample(in_b), .in_valid(ivb),
        .out_data(od_b), .out_valid(ovb), .out_ready(rb),
        .sat_flag(sfb), .ovf_flag(ofb), .clr_flags(clr), .sat_count(scb));

    typedef struct {
        longint x;
        longint y;
    } vec_t;

    typedef struct {
        bit     kept;
        bit     sat;
        longint val;
    } slot_t;

    int     n_chk = 0;
    int     n_fail = 0;

    // Reference state for the DECIM=1 instance
    slot_t  dly[$];
    longint qa[$];
    bit     m_sat, m_ovf;
    int     m_cnt;
    int     na;

    // Reference state for the DECIM=3 instance
    bit     gvb = 1'b0;
    longint gxb = 0;
    int     nb;
    longint exp_b[$];
    longint got_b[$];

    function automatic longint ref_round(input longint x);
        return (x + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    endfunction

    function automatic longint ref_q(input longint x);
        longint r = ref_round(x);
        if (r > 32767)  return 32767;
        if (r < -32768) return -32768;
        return r;
    endfunction

    function automatic bit ref_sat(input longint x);
        longint r = ref_round(x);
        return (r > 32767) || (r < -32768);
    endfunction

    function automatic longint rnd_x();
        longint v = longint'({$urandom, $urandom});
        return v >>> $urandom_range(24, 40);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        slot_t e;
        e.kept = 1'b0; e.sat = 1'b0; e.val = 0;
        dly.delete();
        dly.push_back(e);
        dly.push_back(e);
        qa.delete();
        m_sat = 1'b0; m_ovf = 1'b0; m_cnt = 0; na = 0;
        nb = 0;
        exp_b.delete();
        got_b.delete();
    endtask

    // Drive one clock of stimulus, advance the model over that edge, then compare.
    task automatic cycle(input bit va, input longint xa, input bit rdy, input bit c);
        slot_t s, h;
        bit    pop, full_pre, set_sat, set_ovf;
        iva   = va;
        in_a  = xa[39:0];
        ra    = rdy;
        clr   = c;
        ivb   = gvb;
        in_b  = gxb[39:0];
        if (gvb) begin
            if (nb % 3 == 0) exp_b.push_back(ref_q(gxb));
            nb++;
        end
        s.kept = va && (na % 1 == 0);
        s.sat  = ref_sat(xa);
        s.val  = ref_q(xa);
        if (va) na++;
        h = dly.pop_front();
        dly.push_back(s);
        full_pre = (qa.size() == DEPTH);
        pop      = (qa.size() > 0) && rdy;
        set_sat  = h.kept && h.sat;
        set_ovf  = h.kept && full_pre && !pop;
        if (pop) void'(qa.pop_front());
        if (h.kept && !set_ovf) qa.push_back(h.val);
        m_sat = set_sat ? 1'b1 : (c ? 1'b0 : m_sat);
        m_ovf = set_ovf ? 1'b1 : (c ? 1'b0 : m_ovf);
`ifdef FIR_REQUANT_STATS_EN
        if (set_sat) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        else if (c) m_cnt = 0;
`endif
        @(posedge clk);
        #1;
        chk("out_valid", ova, qa.size() > 0);
        if (qa.size() > 0) chk("out_data", od_a, qa[0]);
        chk("sat_flag", sfa, m_sat);
        chk("ovf_flag", ofa, m_ovf);
        chk("sat_count", sca, m_cnt);
    endtask

    always @(negedge clk) begin
        if (ovb && rb) got_b.push_back(longint'(od_b));
    end

    vec_t tab[11];

    initial begin
        longint exp_cnt;
        tab[0]  = '{32768, 1};
        tab[1]  = '{16384, 1};
        tab[2]  = '{-16384, 0};
        tab[3]  = '{-16385, -1};
        tab[4]  = '{-32768, -1};
        tab[5]  = '{0, 0};
        tab[6]  = '{64'sd1073709056, 32767};
        tab[7]  = '{-64'sd1073741824, -32768};
        tab[8]  = '{64'sd1073725440, 32767};
        tab[9]  = '{64'sd2147483648, 32767};
        tab[10] = '{-64'sd2148532224, -32768};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", ova, 0);
        chk("reset out_data", od_a, 0);
        chk("reset sat_count", sca, 0);
        rst_n = 1'b1;

        // Back-to-back vectors; each output appears two edges after its input
        for (int i = 0; i < 13; i++) begin
            if (i < 11) cycle(1'b1, tab[i].x, 1'b1, 1'b0);
            else        cycle(1'b0, 0, 1'b1, 1'b0);
            if (i >= 2) begin
                chk("vec valid", ova, 1);
                chk("vec data", od_a, tab[i-2].y);
            end
            if (i == 9) chk("no sat yet", sfa, 0);
        end
        cycle(1'b0, 0, 1'b1, 1'b0);
`ifdef FIR_REQUANT_STATS_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        chk("sat_flag set", sfa, 1);
        chk("ovf_flag clear", ofa, 0);
        chk("sat_count after table", sca, exp_cnt);
        cycle(1'b0, 0, 1'b1, 1'b1);
        chk("sat_flag cleared", sfa, 0);
        chk("sat_count cleared", sca, 0);

        // Overflow: six kept samples into a stalled FIFO of four
        for (int n = 1; n <= 6; n++) cycle(1'b1, longint'(n) * 32768, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("ovf valid", ova, 1);
        chk("ovf flag", ofa, 1);
        for (int n = 1; n <= 4; n++) begin
            chk("drain order", od_a, n);
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
        chk("drained empty", ova, 0);
        cycle(1'b0, 0, 1'b1, 1'b1);

        // Full FIFO with push and pop on the same edge
        for (int n = 10; n <= 14; n++) cycle(1'b1, longint'(n) * 32768, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        chk("full+pop no ovf", ofa, 0);
        for (int n = 11; n <= 14; n++) begin
            chk("full+pop order", od_a, n);
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
        chk("full+pop empty", ova, 0);

        // DECIM=3: nine consecutive samples, then valid gaps
        for (int n = 0; n < 9; n++) begin
            gvb = 1'b1;
            gxb = longint'(n) * 32768;
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
        gvb = 1'b0;
        repeat (5) cycle(1'b0, 0, 1'b1, 1'b0);
        chk("decim count", got_b.size(), 3);
        if (got_b.size() == 3) begin
            chk("decim 0", got_b[0], 0);
            chk("decim 1", got_b[1], 3);
            chk("decim 2", got_b[2], 6);
        end
        got_b.delete();
        exp_b.delete();
        for (int n = 0; n < 90; n++) begin
            gvb = ($urandom_range(0, 9) < 5);
            gxb = rnd_x();
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
        gvb = 1'b0;
        repeat (5) cycle(1'b0, 0, 1'b1, 1'b0);
        chk("decim rand count", got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            chk("decim rand data", got_b[i], exp_b[i]);

        // Random traffic with backpressure and occasional flag clears
        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 9) < 8, rnd_x(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 31) == 0);
        repeat (8) cycle(1'b0, 0, 1'b1, 1'b0);

        // Asynchronous reset with three samples buffered, one saturated
        cycle(1'b1, 5 * 32768, 1'b0, 1'b1);
        cycle(1'b1, 64'sd2147483648, 1'b0, 1'b0);
        cycle(1'b1, 7 * 32768, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        chk("pre-reset valid", ova, 1);
        chk("pre-reset sat", sfa, 1);
        #2;
        rst_n = 1'b0;
        iva = 1'b0;
        ra = 1'b0;
        #1;
        chk("async out_valid", ova, 0);
        chk("async sat_flag", sfa, 0);
        chk("async ovf_flag", ofa, 0);
        chk("async sat_count", sca, 0);
        chk("async out_data", od_a, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 9 * 32768, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        chk("post-reset valid", ova, 1);
        chk("post-reset data", od_a, 9);
        cycle(1'b0, 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_requant_decim.md
# fir_requant_decim

Output stage placed directly downstream of the pipelined FIR filter. It takes the filter's 40-bit signed accumulator output every cycle, rounds and saturates it back to a 16-bit sample, and decimates by a fixed factor. The result is buffered in a small FIFO and presented to the consumer (DAC serializer or capture logic) over a valid/ready handshake. It also flags saturation and overflow events.

## Interface
- Parameters:
- `IN_W`, 40: input width; matches filter output (16+16+log2(170)).
- `OUT_W`, 16: output sample width.
- `SHIFT`, 15: right-shift applied before saturation; coefficients are Q15. Legal range 1..IN_W-OUT_W.
- `DECIM`, 1: decimation factor. 1 means keep every sample. Legal range 1..256.
- `DEPTH`, 4: FIFO depth. Must be a power of 2, ≥2.
- Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_sample`, in, IN_W signed: filter output.
- `in_valid`, in, 1: `in_sample` is valid this cycle.
- `out_data`, out, OUT_W signed: head-of-FIFO sample.
- `out_valid`, out, 1: FIFO non-empty.
- `out_ready`, in, 1: consumer accepts `out_data` this cycle.
- `sat_flag`, out, 1: sticky; set when any kept sample saturated.
- `ovf_flag`, out, 1: sticky; set when a kept sample was dropped because the FIFO was full.
- `clr_flags`, in, 1: synchronous clear of both sticky flags.
- `sat_count`, out, 16: saturation event counter (see Configuration).

## Operation
- Stage R (round), registered:
  - `r = (in_sample + 2^(SHIFT-1)) >>> SHIFT`, computed at IN_W+1 bits.
  - Rounding is half-up, toward +inf: 16384 → 1, −16384 → 0, −16385 → −1 for SHIFT=15.
  - `in_valid` is carried alongside.
- Stage S (saturate/decimate), registered:
  - If `r > 2^(OUT_W-1)-1`, clamp to 32767. If `r < −2^(OUT_W-1)`, clamp to −32768. Either case sets `sat_hit`.
  - Phase counter `ph` (0..DECIM-1) advances only on valid stage-R samples and wraps DECIM-1 → 0.
  - A sample is kept when its `ph == 0`. Discarded samples never set flags or count.
- FIFO, first-word-fall-through:
  - A kept sample is pushed.
  - A pop happens when `out_valid && out_ready`.
  - Full and no pop in the same cycle: the sample is dropped, `ovf_flag` is set, and the FIFO is unchanged.
  - Full with a simultaneous pop: the push is accepted, and occupancy stays at DEPTH.
  - Empty with a push: no pop is possible that cycle, since `out_valid` was low.
  - Pointers wrap modulo DEPTH. Occupancy counter runs 0..DEPTH.
- Flags:
  - `sat_flag` is set on a kept saturated sample, including one that is dropped for overflow.
  - When `clr_flags` coincides with a set event, the set wins.
- Reset:
  - All pipeline registers, `ph`, pointers, occupancy, flags and `sat_count` go to 0.
  - `out_valid`=0 and `out_data`=0.
  - Reset mid-stream discards all in-flight and buffered samples. After release, the first sample with `in_valid` high is phase 0.

## Timing
- A sample sampled with `in_valid` at edge k is registered in R at k and in S at k+1. It is written to the FIFO at edge k+2.
- `out_valid` and `out_data` reflect it after edge k+2, giving a 2-cycle latency into an empty FIFO.
- Sustained throughput is 1 sample/cycle in, 1/DECIM out.
- `out_data` holds stable while `out_valid && !out_ready`.
- Flags update at the same edge as the FIFO write decision (k+2).
- `clr_flags` takes effect at the next edge.

## Configuration
- `FIR_REQUANT_STATS_EN` defined:
  - `sat_count` is a 16-bit counter of saturated kept samples.
  - It saturates at 65535 and does not wrap.
  - It is cleared by `clr_flags` or reset. A coincident increment wins over `clr_flags`.
- `FIR_REQUANT_STATS_EN` undefined:
  - The counter logic is absent and `sat_count` is tied to 0.
  - All other behaviour is identical.

## Structure
- Shared package `fir_pkg` holds:
  - `FIR_IN_W`=40, `FIR_OUT_W`=16, `FIR_COEF_FRAC`=15.
  - Typedefs `fir_acc_t` (signed [39:0]) and `fir_sample_t` (signed [15:0]).
  - These are used as parameter defaults here and in the filter.
- One sub-module, `fir_out_fifo`: a parameterised FWFT synchronous FIFO with push, pop, full, empty and data outputs.
- Round, saturate, decimate and flag logic stay in the top module.

## Test plan
- SHIFT=15, DECIM=1, `out_ready`=1. Drive 32768, 16384, −16384, −16385, −32768 on consecutive cycles → out 1, 1, 0, −1, −1, each 2 cycles after its input. No flags set.
- Drive 2^31, then −2^31−2^20 → out 32767 then −32768. `sat_flag`=1, and `sat_count`=2 with the macro (0 without). Then pulse `clr_flags` → both clear.
- DECIM=3. Drive 9 consecutive valid samples 32768·n for n=0..8 → outputs 0, 3, 6 only. Insert `in_valid` gaps and confirm the phase advances only on valid samples.
- DEPTH=4, `out_ready`=0. Push 6 kept samples → `out_valid`=1, the first 4 samples are retained, and `ovf_flag`=1. Raise `out_ready` → 4 samples drain in order, then `out_valid`=0.
- FIFO full with `out_ready`=1 and a push in the same cycle → occupancy stays 4, no overflow, order preserved.
- Assert `rst_n`=0 asynchronously mid-stream with 3 samples buffered → `out_valid`, flags and `sat_count` drop to 0 immediately. After release, the first output corresponds to the first post-reset input.
